// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared types and constants for the sequential divider
//
// Contents:
//   DEFAULT_BIT : default operand/result width
//   state_t     : controller states (IDLE, CALC, DONE)
package seq_divider_pkg;

  localparam int DEFAULT_BIT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
//
// Ports:
//   rem_i     in  BIT  current partial remainder
//   bit_i     in  1    next dividend bit shifted into the remainder
//   divisor_i in  BIT  divisor
//   rem_o     out BIT  partial remainder after this step
//   q_o       out 1    quotient bit produced by this step
//
// The trial subtraction is a BIT+1 wide ripple-carry adder in subtract mode
// (a + ~b + 1). The stored remainder is always below the divisor, so it fits
// in BIT bits; only the shifted trial value needs the extra bit.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int BIT = DEFAULT_BIT
) (
  input  logic [BIT-1:0] rem_i,
  input  logic           bit_i,
  input  logic [BIT-1:0] divisor_i,
  output logic [BIT-1:0] rem_o,
  output logic           q_o
);

  localparam int W = BIT + 1;

  logic [W-1:0] shifted;
  logic [W-1:0] sub_b;
  logic [W-1:0] diff;
  logic [W-1:0] carry;

  assign shifted = {rem_i, bit_i};
  assign sub_b   = ~{1'b0, divisor_i};

  // carry[0] = 1 supplies the +1 of the two's-complement subtraction
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_sum
    assign diff[i] = shifted[i] ^ sub_b[i] ^ carry[i];
  end

  for (genvar i = 0; i < W - 1; i++) begin : g_carry
    assign carry[i+1] = (shifted[i] & sub_b[i]) | (carry[i] & (shifted[i] ^ sub_b[i]));
  end

  // A clear sign bit means the divisor fitted: keep the difference and emit 1
  assign q_o   = ~diff[BIT];
  assign rem_o = q_o ? diff[BIT-1:0] : shifted[BIT-1:0];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative restoring divider, one quotient bit per clock
//
// Ports:
//   clk_i       in  1    clock, rising edge
//   rst_i       in  1    asynchronous active-high reset
//   start_i     in  1    request, accepted only while ready_o=1
//   dividend_i  in  BIT  dividend, sampled on the accepting edge
//   divisor_i   in  BIT  divisor, sampled on the accepting edge
//   signed_i    in  1    two's-complement operands (only with SEQ_DIVIDER_SIGNED_EN)
//   ready_o     out 1    high only in IDLE
//   done_o      out 1    one-cycle pulse, results valid
//   quotient_o  out BIT  quotient, held until the next accept
//   remainder_o out BIT  remainder, held until the next accept
//   div_zero_o  out 1    divisor was zero, held with the results
//
// Optional feature macro: SEQ_DIVIDER_SIGNED_EN (signed operand support).
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int BIT = DEFAULT_BIT
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [BIT-1:0] dividend_i,
  input  logic [BIT-1:0] divisor_i,
`ifdef SEQ_DIVIDER_SIGNED_EN
  input  logic           signed_i,
`endif
  output logic           ready_o,
  output logic           done_o,
  output logic [BIT-1:0] quotient_o,
  output logic [BIT-1:0] remainder_o,
  output logic           div_zero_o
);

  localparam int            CW   = $clog2(BIT);
  localparam logic [CW-1:0] LAST = CW'(BIT - 1);

  state_t          state;
  logic [CW-1:0]   count;
  logic [BIT-1:0]  rem_q;
  logic [BIT-1:0]  quo_q;
  logic [BIT-1:0]  dvs_q;

  logic [BIT-1:0]  step_rem;
  logic            step_bit;
  logic [BIT-1:0]  quo_next;

  logic [BIT-1:0]  dividend_mag;
  logic [BIT-1:0]  divisor_mag;
  logic [BIT-1:0]  quo_final;
  logic [BIT-1:0]  rem_final;

  // The dividend is shifted out of the top of Q while quotient bits enter at
  // the bottom, so a single register serves as both.
  div_step #(
    .BIT(BIT)
  ) u_step (
    .rem_i     (rem_q),
    .bit_i     (quo_q[BIT-1]),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_bit)
  );

  assign quo_next = {quo_q[BIT-2:0], step_bit};

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic dividend_neg;
  logic divisor_neg;
  logic neg_quo_q;
  logic neg_rem_q;

  assign dividend_neg = signed_i & dividend_i[BIT-1];
  assign divisor_neg  = signed_i & divisor_i[BIT-1];
  // -MIN wraps to MIN, which read as unsigned is the correct magnitude
  assign dividend_mag = dividend_neg ? -dividend_i : dividend_i;
  assign divisor_mag  = divisor_neg ? -divisor_i : divisor_i;
  assign quo_final    = neg_quo_q ? -quo_next : quo_next;
  assign rem_final    = neg_rem_q ? -step_rem : step_rem;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (state == IDLE && start_i) begin
      neg_quo_q <= dividend_neg ^ divisor_neg;
      neg_rem_q <= dividend_neg;
    end
  end
`else
  assign dividend_mag = dividend_i;
  assign divisor_mag  = divisor_i;
  assign quo_final    = quo_next;
  assign rem_final    = step_rem;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      count       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      quotient_o  <= '0;
      remainder_o <= '0;
      div_zero_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            if (divisor_i == '0) begin
              quotient_o  <= '1;
              remainder_o <= dividend_i;
              div_zero_o  <= 1'b1;
              state       <= DONE;
            end else begin
              rem_q      <= '0;
              quo_q      <= dividend_mag;
              dvs_q      <= divisor_mag;
              count      <= '0;
              div_zero_o <= 1'b0;
              state      <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= step_rem;
          quo_q <= quo_next;
          count <= count + CW'(1);
          if (count == LAST) begin
            quotient_o  <= quo_final;
            remainder_o <= rem_final;
            state       <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign ready_o = (state == IDLE);
  assign done_o  = (state == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - scoreboard testbench for seq_divider
module tb_seq_divider;

  localparam int BIT = 32;

  typedef struct {
    logic [BIT-1:0] q;
    logic [BIT-1:0] r;
    logic           dz;
  } exp_t;

  logic           clk_i;
  logic           rst_i;
  logic           start_i;
  logic [BIT-1:0] dividend_i;
  logic [BIT-1:0] divisor_i;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic           signed_i;
`endif
  logic           ready_o;
  logic           done_o;
  logic [BIT-1:0] quotient_o;
  logic [BIT-1:0] remainder_o;
  logic           div_zero_o;

  int   n_cmp;
  int   n_err;
  exp_t sb[$];
  logic prev_done;

  seq_divider #(
    .BIT(BIT)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
`ifdef SEQ_DIVIDER_SIGNED_EN
    .signed_i    (signed_i),
`endif
    .ready_o     (ready_o),
    .done_o      (done_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o),
    .div_zero_o  (div_zero_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain integer division, wide enough that MIN/-1 cannot overflow
  function automatic exp_t model(input logic [BIT-1:0] a, input logic [BIT-1:0] b, input logic s);
    exp_t   e;
    longint sa;
    longint sb_v;
    if (b == 0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else if (s) begin
      sa   = longint'($signed(a));
      sb_v = longint'($signed(b));
      e.q  = BIT'(sa / sb_v);
      e.r  = BIT'(sa % sb_v);
      e.dz = 1'b0;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: every done pulse consumes one expected result
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i && done_o) begin
      check("done_width", {63'd0, prev_done}, 64'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("quotient", {32'd0, quotient_o}, {32'd0, e.q});
        check("remainder", {32'd0, remainder_o}, {32'd0, e.r});
        check("div_zero", {63'd0, div_zero_o}, {63'd0, e.dz});
      end
    end
    prev_done = done_o & ~rst_i;
  end

  // Drive one request at a falling edge; returns just after the accepting edge
  task automatic start_op(input logic [BIT-1:0] a, input logic [BIT-1:0] b,
                          input logic s, input bit push);
    int k;
    k = 0;
    @(negedge clk_i);
    while (!ready_o && k < 200) begin
      @(negedge clk_i);
      k++;
    end
    if (!ready_o) check("ready_timeout", 64'd0, 64'd1);
    if (push) sb.push_back(model(a, b, s));
    start_i    = 1'b1;
    dividend_i = a;
    divisor_i  = b;
`ifdef SEQ_DIVIDER_SIGNED_EN
    signed_i   = s;
`endif
    @(posedge clk_i);
    #1;
    start_i    = 1'b0;
    dividend_i = $urandom;
    divisor_i  = $urandom;
  endtask

  // Count falling edges until done_o; then ready_o must be back the cycle after
  task automatic wait_done(input string name, input int exp_lat);
    int k;
    k = 0;
    do begin
      @(negedge clk_i);
      k++;
    end while (!done_o && k < 100);
    check(name, 64'(k), 64'(exp_lat));
    @(negedge clk_i);
    check("ready_after_done", {63'd0, ready_o}, 64'd1);
  endtask

  initial begin
    logic [BIT-1:0] a;
    logic [BIT-1:0] b;
    logic           s;
    n_cmp      = 0;
    n_err      = 0;
    prev_done  = 1'b0;
    rst_i      = 1'b1;
    start_i    = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
    signed_i   = 1'b0;
`endif
    repeat (2) @(negedge clk_i);
    check("rst_ready", {63'd0, ready_o}, 64'd1);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_quotient", {32'd0, quotient_o}, 64'd0);
    check("rst_remainder", {32'd0, remainder_o}, 64'd0);
    check("rst_div_zero", {63'd0, div_zero_o}, 64'd0);
    rst_i = 1'b0;

    start_op(32'd100, 32'd7, 1'b0, 1'b1);
    wait_done("lat_100_7", BIT + 1);
    start_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
    wait_done("lat_max_1", BIT + 1);
    start_op(32'd5, 32'd9, 1'b0, 1'b1);
    wait_done("lat_5_9", BIT + 1);
    start_op(32'd1234, 32'd0, 1'b0, 1'b1);
    wait_done("lat_div0", 1);

    // A second start during CALC must be dropped
    start_op(32'd1000, 32'd3, 1'b0, 1'b1);
    repeat (5) @(negedge clk_i);
    start_i    = 1'b1;
    dividend_i = 32'd77;
    divisor_i  = 32'd2;
    @(negedge clk_i);
    start_i    = 1'b0;
    wait_done("lat_ignore", BIT + 1 - 6);

    // Reset with the step counter at 10 discards the division
    start_op(32'd999, 32'd4, 1'b0, 1'b0);
    repeat (10) @(posedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    check("midrst_ready", {63'd0, ready_o}, 64'd1);
    check("midrst_done", {63'd0, done_o}, 64'd0);
    check("midrst_quotient", {32'd0, quotient_o}, 64'd0);
    check("midrst_remainder", {32'd0, remainder_o}, 64'd0);
    check("midrst_div_zero", {63'd0, div_zero_o}, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    start_op(32'd50, 32'd5, 1'b0, 1'b1);
    wait_done("lat_50_5", BIT + 1);

`ifdef SEQ_DIVIDER_SIGNED_EN
    start_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1);
    wait_done("lat_signed_m7_2", BIT + 1);
    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_done("lat_min_m1", BIT + 1);
`endif

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       b = '0;
        1, 2, 3: b = BIT'($urandom_range(1, 20));
        4, 5:    b = a >> $urandom_range(0, 8);
        default: b = $urandom >> $urandom_range(0, 24);
      endcase
      s = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      s = 1'($urandom_range(0, 1));
`endif
      start_op(a, b, s, 1'b1);
      wait_done("lat_random", (b == 0) ? 1 : BIT + 1);
    end

    repeat (40) @(negedge clk_i);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
